// File: rtl/io_2to1_pkg.sv
// io_2to1_pkg
//   Shared definitions for the 2-to-1 merge traffic harness:
//   - default address/data field widths
//   - NS_ON / NS_OFF logic constants used for handshake lines
//   - source FSM state type (IDLE / REQ)
//   - saturating increment for the 16-bit receive counters
//
// Optional feature macro used by io_2to1: NS_IO_2TO1_FST_ERR_EN
//   (first-error capture registers).

package io_2to1_pkg;

  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 8;

  // Width of the rolling per-source sequence number carried in dat[3:0].
  localparam int SEQ_W = 4;
  // Width of the per-source accepted-message counters.
  localparam int CNT_W = 16;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } src_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/io_2to1_src.sv
// io_2to1_src
//   One traffic source of the 2-to-1 harness. Drives a four-phase
//   req/ack channel with messages whose data is a rolling 4-bit
//   sequence number (zero-extended to DSZ). Stops after NUM_MSG
//   messages when NUM_MSG is non-zero; runs forever otherwise.
//
// Parameters
//   SRC_ADDR  value driven on src
//   DST_ADDR  value driven on dst
//   NUM_MSG   messages to send, 0 = unlimited
//   ASZ, DSZ  address / data field widths
//
// Ports
//   i_clk  in   clock
//   i_rst  in   synchronous active-high reset
//   src    out  ASZ  source address (constant)
//   dst    out  ASZ  destination address (constant)
//   dat    out  DSZ  message data, stable while req is high
//   req    out  1    request
//   ack    in   1    acknowledge from the consumer
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | req low; waits for ack low and not exhausted, then loads dat
// REQ   | req high; waits for ack, then drops req and advances cnt

module io_2to1_src
  import io_2to1_pkg::*;
#(
  parameter int unsigned SRC_ADDR = 1,
  parameter int unsigned DST_ADDR = 3,
  parameter int unsigned NUM_MSG  = 0,
  parameter int unsigned ASZ      = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ      = NS_DATA_SIZE
) (
  input  logic           i_clk,
  input  logic           i_rst,
  output logic [ASZ-1:0] src,
  output logic [ASZ-1:0] dst,
  output logic [DSZ-1:0] dat,
  output logic           req,
  input  logic           ack
);

  src_state_e       state_q, state_d;
  logic             req_d;
  logic [DSZ-1:0]   dat_d;
  logic [SEQ_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sent_q, sent_d;
  logic             exhausted;

  assign src = ASZ'(SRC_ADDR);
  assign dst = ASZ'(DST_ADDR);

  // sent_q may wrap when NUM_MSG is 0; it is only compared when a limit exists.
  assign exhausted = (NUM_MSG != 0) && (sent_q == NUM_MSG);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      req     <= NS_OFF;
      dat     <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      req     <= req_d;
      dat     <= dat_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req;
    dat_d   = dat;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (!ack && !exhausted) begin
          dat_d   = DSZ'(cnt_q);
          req_d   = NS_ON;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          req_d   = NS_OFF;
          cnt_d   = cnt_q + 1'b1;
          sent_d  = sent_q + 32'd1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = NS_OFF;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/io_2to1.sv
// io_2to1
//   Self-checking traffic harness for 2-to-1 merge/arbitration tests.
//   Two independent sources (io_2to1_src) drive channels o0 and o1;
//   an external arbiter merges them onto i0, which this block consumes
//   and checks for destination, source identity, data range and
//   per-source sequence continuity. Status flags are sticky.
//
// Parameters
//   SRC0_ADDR, SRC1_ADDR  source addresses (must differ)
//   DST_ADDR              the only destination accepted without error
//   NUM_MSG               messages per source, 0 = unlimited
//   ASZ, DSZ              address / data widths (DSZ >= 4)
//
// Ports
//   i_clk, i_rst                     clock, synchronous active-high reset
//   o0_src/dst/dat/req, o0_ack       source-0 channel
//   o1_src/dst/dat/req, o1_ack       source-1 channel
//   i0_src/dst/dat/req, i0_ack       merged sink channel
//   o_ck_dat                         last accepted i0_dat
//   o_err                            sticky error
//   o_rcv_0, o_rcv_1                 accepted counts per source, saturating
//   o_done                           both counts reached NUM_MSG (NUM_MSG != 0)
//   fst_err_src/inp/dat              first failing message: src, data, expected
//
// Optional feature macro: NS_IO_2TO1_FST_ERR_EN
//   defined   -> fst_err_* capture the first failing message and then freeze
//   undefined -> fst_err_* are tied to 0

module io_2to1
  import io_2to1_pkg::*;
#(
  parameter int unsigned SRC0_ADDR = 1,
  parameter int unsigned SRC1_ADDR = 2,
  parameter int unsigned DST_ADDR  = 3,
  parameter int unsigned NUM_MSG   = 0,
  parameter int unsigned ASZ       = NS_ADDRESS_SIZE,
  parameter int unsigned DSZ       = NS_DATA_SIZE
) (
  input  logic             i_clk,
  input  logic             i_rst,

  output logic [ASZ-1:0]   o0_src,
  output logic [ASZ-1:0]   o0_dst,
  output logic [DSZ-1:0]   o0_dat,
  output logic             o0_req,
  input  logic             o0_ack,

  output logic [ASZ-1:0]   o1_src,
  output logic [ASZ-1:0]   o1_dst,
  output logic [DSZ-1:0]   o1_dat,
  output logic             o1_req,
  input  logic             o1_ack,

  input  logic [ASZ-1:0]   i0_src,
  input  logic [ASZ-1:0]   i0_dst,
  input  logic [DSZ-1:0]   i0_dat,
  input  logic             i0_req,
  output logic             i0_ack,

  output logic [DSZ-1:0]   o_ck_dat,
  output logic             o_err,
  output logic [CNT_W-1:0] o_rcv_0,
  output logic [CNT_W-1:0] o_rcv_1,
  output logic             o_done,
  output logic [ASZ-1:0]   fst_err_src,
  output logic [DSZ-1:0]   fst_err_inp,
  output logic [DSZ-1:0]   fst_err_dat
);

  // ---------------------------------------------------------------
  // Sources
  // ---------------------------------------------------------------
  io_2to1_src #(
    .SRC_ADDR (SRC0_ADDR),
    .DST_ADDR (DST_ADDR),
    .NUM_MSG  (NUM_MSG),
    .ASZ      (ASZ),
    .DSZ      (DSZ)
  ) u_src0 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .src   (o0_src),
    .dst   (o0_dst),
    .dat   (o0_dat),
    .req   (o0_req),
    .ack   (o0_ack)
  );

  io_2to1_src #(
    .SRC_ADDR (SRC1_ADDR),
    .DST_ADDR (DST_ADDR),
    .NUM_MSG  (NUM_MSG),
    .ASZ      (ASZ),
    .DSZ      (DSZ)
  ) u_src1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .src   (o1_src),
    .dst   (o1_dst),
    .dat   (o1_dat),
    .req   (o1_req),
    .ack   (o1_ack)
  );

  // ---------------------------------------------------------------
  // Sink and checker
  // ---------------------------------------------------------------
  logic             accept;
  logic             is_src0, is_src1;
  logic             dst_bad, src_bad, dat_bad, seq_bad, any_bad;
  logic [SEQ_W-1:0] last0_q, last1_q;
  logic             base0_q, base1_q;
  logic             base_sel;
  logic [SEQ_W-1:0] seq_exp;
  logic [CNT_W-1:0] rcv0_d, rcv1_d;

  assign accept  = i0_req && !i0_ack;

  assign is_src0 = (i0_src == ASZ'(SRC0_ADDR));
  assign is_src1 = (i0_src == ASZ'(SRC1_ADDR));

  assign dst_bad = (i0_dst != ASZ'(DST_ADDR));
  assign src_bad = !is_src0 && !is_src1;
  assign dat_bad = (i0_dat > DSZ'(15));

  // The 4-bit add wraps, so 15 -> 0 is an expected step.
  assign seq_exp  = (is_src0 ? last0_q : last1_q) + 1'b1;
  assign base_sel = is_src0 ? base0_q : (is_src1 ? base1_q : 1'b0);
  assign seq_bad  = base_sel && (i0_dat[SEQ_W-1:0] != seq_exp);

  assign any_bad = dst_bad || src_bad || dat_bad || seq_bad;

  assign rcv0_d = (accept && is_src0) ? sat_inc(o_rcv_0) : o_rcv_0;
  assign rcv1_d = (accept && is_src1) ? sat_inc(o_rcv_1) : o_rcv_1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      i0_ack   <= NS_OFF;
      o_ck_dat <= '0;
      o_err    <= NS_OFF;
      o_rcv_0  <= '0;
      o_rcv_1  <= '0;
      o_done   <= NS_OFF;
      last0_q  <= '0;
      last1_q  <= '0;
      base0_q  <= NS_OFF;
      base1_q  <= NS_OFF;
    end else begin
      if (accept) begin
        i0_ack   <= NS_ON;
        o_ck_dat <= i0_dat;
        o_err    <= o_err | any_bad;
        // The baseline follows the received value even when it is wrong,
        // so a single corrupt word reports once instead of cascading.
        if (is_src0) begin
          last0_q <= i0_dat[SEQ_W-1:0];
          base0_q <= NS_ON;
        end
        if (is_src1) begin
          last1_q <= i0_dat[SEQ_W-1:0];
          base1_q <= NS_ON;
        end
      end else if (!i0_req && i0_ack) begin
        i0_ack <= NS_OFF;
      end
      o_rcv_0 <= rcv0_d;
      o_rcv_1 <= rcv1_d;
      // Evaluated on the next counts so done lines up with the final ack.
      o_done  <= (NUM_MSG != 0) &&
                 (32'(rcv0_d) == NUM_MSG) &&
                 (32'(rcv1_d) == NUM_MSG);
    end
  end

  // ---------------------------------------------------------------
  // First-error capture
  // ---------------------------------------------------------------
`ifdef NS_IO_2TO1_FST_ERR_EN
  logic fst_vld_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fst_vld_q   <= NS_OFF;
      fst_err_src <= '0;
      fst_err_inp <= '0;
      fst_err_dat <= '0;
    end else if (accept && any_bad && !fst_vld_q) begin
      fst_vld_q   <= NS_ON;
      fst_err_src <= i0_src;
      fst_err_inp <= i0_dat;
      // Expected data is only meaningful for a sequence failure.
      fst_err_dat <= seq_bad ? DSZ'(seq_exp) : '0;
    end
  end
`else
  assign fst_err_src = '0;
  assign fst_err_inp = '0;
  assign fst_err_dat = '0;
`endif

endmodule

// File: tb/tb_io_2to1.sv
`timescale 1ns/1ps
module tb_io_2to1;
  import io_2to1_pkg::*;

  localparam int unsigned SRC0 = 1;
  localparam int unsigned SRC1 = 2;
  localparam int unsigned DST  = 3;
  localparam int unsigned NUM  = 20;
  localparam int unsigned ASZ  = 8;
  localparam int unsigned DSZ  = 8;

  localparam int K_NONE = 0;
  localparam int K_DAT  = 1;
  localparam int K_DST  = 2;
  localparam int K_SRC  = 3;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [ASZ-1:0] o0_src, o0_dst, o1_src, o1_dst, i0_src, i0_dst, fst_err_src;
  logic [DSZ-1:0] o0_dat, o1_dat, i0_dat, o_ck_dat, fst_err_inp, fst_err_dat;
  logic           o0_req, o0_ack, o1_req, o1_ack, i0_req, i0_ack;
  logic           o_err, o_done;
  logic [15:0]    o_rcv_0, o_rcv_1;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what each source should send next, and what
  // the sink should have recorded so far.
  int exp_seq [2];
  int sent    [2];
  int m_rcv   [2];
  int m_last  [2];
  bit m_base  [2];
  bit m_err;
  bit m_fst_vld;
  int m_fst_src, m_fst_inp, m_fst_dat;

  io_2to1 #(
    .SRC0_ADDR (SRC0),
    .SRC1_ADDR (SRC1),
    .DST_ADDR  (DST),
    .NUM_MSG   (NUM),
    .ASZ       (ASZ),
    .DSZ       (DSZ)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o0_src      (o0_src),
    .o0_dst      (o0_dst),
    .o0_dat      (o0_dat),
    .o0_req      (o0_req),
    .o0_ack      (o0_ack),
    .o1_src      (o1_src),
    .o1_dst      (o1_dst),
    .o1_dat      (o1_dat),
    .o1_req      (o1_req),
    .o1_ack      (o1_ack),
    .i0_src      (i0_src),
    .i0_dst      (i0_dst),
    .i0_dat      (i0_dat),
    .i0_req      (i0_req),
    .i0_ack      (i0_ack),
    .o_ck_dat    (o_ck_dat),
    .o_err       (o_err),
    .o_rcv_0     (o_rcv_0),
    .o_rcv_1     (o_rcv_1),
    .o_done      (o_done),
    .fst_err_src (fst_err_src),
    .fst_err_inp (fst_err_inp),
    .fst_err_dat (fst_err_dat)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  function automatic logic req_of(input int s);
    return (s != 0) ? o1_req : o0_req;
  endfunction

  task automatic set_ack(input int s, input logic v);
    if (s != 0) o1_ack = v;
    else        o0_ack = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_seq[i] = 0;
      sent[i]    = 0;
      m_rcv[i]   = 0;
      m_last[i]  = 0;
      m_base[i]  = 1'b0;
    end
    m_err     = 1'b0;
    m_fst_vld = 1'b0;
    m_fst_src = 0;
    m_fst_inp = 0;
    m_fst_dat = 0;
  endtask

  task automatic do_reset(input int cycles);
    i_rst  = 1'b1;
    i0_req = 1'b0;
    o0_ack = 1'b0;
    o1_ack = 1'b0;
    repeat (cycles) tick();
    i_rst = 1'b0;
    model_reset();
  endtask

  // Carry one message from source s to the sink, optionally corrupting one
  // field on the way, and compare the sink's state against the model.
  task automatic send(input int s, input int kind, input int val);
    int n;
    int sf, df, xf, k, sexp;
    bit known, bad, sbad;
    logic [DSZ-1:0] tdat;
    n = 0;
    while (!req_of(s) && n < 40) begin
      tick();
      n++;
    end
    if (!req_of(s)) begin
      chk($sformatf("src%0d_req_timeout", s), 32'(req_of(s)), 32'd1);
      return;
    end
    tdat = (s != 0) ? o1_dat : o0_dat;
    chk($sformatf("src%0d_dat", s), 32'(tdat), 32'(exp_seq[s]));
    sf = (s != 0) ? int'(o1_src) : int'(o0_src);
    df = (s != 0) ? int'(o1_dst) : int'(o0_dst);
    xf = int'(tdat);
    case (kind)
      K_DAT:   xf = val;
      K_DST:   df = val;
      K_SRC:   sf = val;
      default: ;
    endcase
    i0_src = ASZ'(sf);
    i0_dst = ASZ'(df);
    i0_dat = DSZ'(xf);
    i0_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!i0_ack && n < 10);
    chk("ack_latency", 32'(n), 32'd1);

    known = (sf == int'(SRC0)) || (sf == int'(SRC1));
    k     = (sf == int'(SRC1)) ? 1 : 0;
    bad   = (df != int'(DST)) || !known || (xf > 15);
    sbad  = 1'b0;
    sexp  = 0;
    if (known && m_base[k]) begin
      sexp = (m_last[k] + 1) % 16;
      if ((xf % 16) != sexp) begin
        bad  = 1'b1;
        sbad = 1'b1;
      end
    end
    if (known) begin
      m_last[k] = xf % 16;
      m_base[k] = 1'b1;
      if (m_rcv[k] < 65535) m_rcv[k]++;
    end
    if (bad && !m_fst_vld) begin
      m_fst_vld = 1'b1;
      m_fst_src = sf;
      m_fst_inp = xf;
      m_fst_dat = sbad ? sexp : 0;
    end
    m_err = m_err || bad;

    chk("ck_dat", 32'(o_ck_dat), 32'(xf));
    chk("err", 32'(o_err), 32'(m_err));
    chk("rcv_0", 32'(o_rcv_0), 32'(m_rcv[0]));
    chk("rcv_1", 32'(o_rcv_1), 32'(m_rcv[1]));
    chk("done", 32'(o_done), 32'(m_rcv[0] == int'(NUM) && m_rcv[1] == int'(NUM)));
`ifdef NS_IO_2TO1_FST_ERR_EN
    chk("fst_err_src", 32'(fst_err_src), 32'(m_fst_src));
    chk("fst_err_inp", 32'(fst_err_inp), 32'(m_fst_inp));
    chk("fst_err_dat", 32'(fst_err_dat), 32'(m_fst_dat));
`else
    chk("fst_err_src", 32'(fst_err_src), 32'd0);
    chk("fst_err_inp", 32'(fst_err_inp), 32'd0);
    chk("fst_err_dat", 32'(fst_err_dat), 32'd0);
`endif

    set_ack(s, 1'b1);
    n = 0;
    while (req_of(s) && n < 10) begin
      tick();
      n++;
    end
    chk($sformatf("src%0d_req_fall", s), 32'(req_of(s)), 32'd0);
    i0_req = 1'b0;
    n = 0;
    while (i0_ack && n < 10) begin
      tick();
      n++;
    end
    chk("ack_fall", 32'(i0_ack), 32'd0);
    set_ack(s, 1'b0);
    exp_seq[s] = (exp_seq[s] + 1) % 16;
    sent[s]++;
  endtask

  // Randomized arbitration between the two sources until both are done.
  task automatic mix(input bit corrupt);
    int guard;
    int s, kind, val;
    guard = 0;
    while ((sent[0] < int'(NUM) || sent[1] < int'(NUM)) && guard < 400) begin
      guard++;
      if (o0_req && o1_req) s = int'($urandom_range(0, 1));
      else if (o0_req)      s = 0;
      else if (o1_req)      s = 1;
      else begin
        tick();
        continue;
      end
      kind = K_NONE;
      val  = 0;
      if (corrupt && $urandom_range(0, 5) == 0) begin
        kind = int'($urandom_range(1, 3));
        if (kind == K_DAT)      val = int'($urandom_range(0, 31));
        else if (kind == K_DST) val = int'($urandom_range(0, 3));
        else                    val = int'($urandom_range(0, 15));
      end
      send(s, kind, val);
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("mix_complete", 32'(sent[0] + sent[1]), 32'(2 * NUM));
  endtask

  initial begin
    int n;
    i_rst  = 1'b1;
    i0_req = 1'b0;
    i0_src = '0;
    i0_dst = '0;
    i0_dat = '0;
    o0_ack = 1'b0;
    o1_ack = 1'b0;
    model_reset();
    repeat (3) tick();

    chk("rst_o0_req", 32'(o0_req), 32'd0);
    chk("rst_o1_req", 32'(o1_req), 32'd0);
    chk("rst_i0_ack", 32'(i0_ack), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_rcv_0", 32'(o_rcv_0), 32'd0);
    chk("rst_rcv_1", 32'(o_rcv_1), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ck_dat", 32'(o_ck_dat), 32'd0);
    chk("rst_fst_src", 32'(fst_err_src), 32'd0);
    i_rst = 1'b0;

    // Loopback of source 0 only; source 1 is never acknowledged.
    for (int i = 0; i < int'(NUM); i++) send(0, K_NONE, 0);
    repeat (4) tick();
    chk("exhaust_o0_req", 32'(o0_req), 32'd0);
    chk("o1_req_stuck", 32'(o1_req), 32'd1);
    chk("done_one_src", 32'(o_done), 32'd0);
    chk("loop_rcv_0", 32'(o_rcv_0), 32'(NUM));
    chk("loop_err", 32'(o_err), 32'd0);

    // Clean randomized arbitration.
    do_reset(2);
    mix(1'b0);
    chk("arb_done", 32'(o_done), 32'd1);
    repeat (5) tick();
    chk("arb_o0_idle", 32'(o0_req), 32'd0);
    chk("arb_o1_idle", 32'(o1_req), 32'd0);
    chk("arb_err", 32'(o_err), 32'd0);

    // Sequence corruption: 5 replaced by 7, then 8, then a forced dst error.
    do_reset(1);
    for (int i = 0; i < 5; i++) send(0, K_NONE, 0);
    send(0, K_DAT, 7);
    chk("seq_err_set", 32'(o_err), 32'd1);
    send(0, K_DAT, 8);
    send(0, K_DST, 0);
    send(0, K_NONE, 0);

    // Destination corruption on source 1: counted, but flagged.
    do_reset(1);
    send(1, K_NONE, 0);
    send(1, K_NONE, 0);
    send(1, K_DST, 0);
    chk("dst_err_rcv_1", 32'(o_rcv_1), 32'd3);
    send(1, K_NONE, 0);

    // Unknown source: flagged and not counted.
    do_reset(1);
    send(0, K_NONE, 0);
    send(0, K_SRC, 9);
    chk("src_err_rcv_0", 32'(o_rcv_0), 32'd1);
    chk("src_err_rcv_1", 32'(o_rcv_1), 32'd0);
    send(1, K_NONE, 0);

    // Randomized arbitration with random corruption.
    do_reset(1);
    mix(1'b1);

    // Reset in the middle of a handshake.
    do_reset(1);
    n = 0;
    while (!o0_req && n < 10) begin
      tick();
      n++;
    end
    i0_src = o0_src;
    i0_dst = o0_dst;
    i0_dat = o0_dat;
    i0_req = 1'b1;
    tick();
    chk("mid_ack_high", 32'(i0_ack), 32'd1);
    chk("mid_o0_req_high", 32'(o0_req), 32'd1);
    i_rst = 1'b1;
    tick();
    chk("mid_rst_o0_req", 32'(o0_req), 32'd0);
    chk("mid_rst_o1_req", 32'(o1_req), 32'd0);
    chk("mid_rst_i0_ack", 32'(i0_ack), 32'd0);
    chk("mid_rst_rcv_0", 32'(o_rcv_0), 32'd0);
    chk("mid_rst_err", 32'(o_err), 32'd0);
    i_rst  = 1'b0;
    i0_req = 1'b0;
    o0_ack = 1'b0;
    o1_ack = 1'b0;
    model_reset();
    send(0, K_NONE, 0);
    chk("post_rst_err", 32'(o_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_2to1.md
# io_2to1

Self-checking traffic harness for 2-to-1 merge/arbitration tests. It mirrors the 1-to-2 harness: two independent sources each drive an output channel, and one sink consumes the merged channel. Every accepted message is checked for destination, source identity and per-source sequence continuity. Status flags are sticky and sized for LEDs/debug taps on FPGA test boards.

## Interface
Parameters:
- SRC0_ADDR, 1: value driven on o0_src; sink tags messages carrying it as source 0.
- SRC1_ADDR, 2: value driven on o1_src; sink tags messages carrying it as source 1. Must differ from SRC0_ADDR.
- DST_ADDR, 3: value driven on o0_dst/o1_dst; the only dst the sink accepts without error.
- NUM_MSG, 0: messages per source; 0 means unlimited.
- ASZ, `NS_ADDRESS_SIZE: address field width.
- DSZ, `NS_DATA_SIZE: data field width, ≥ 4.

Ports:
- i_clk  in  1  single clock for all logic.
- i_rst  in  1  synchronous, active-high reset.
- o0_src/o0_dst/o0_dat/o0_req  out  ASZ/ASZ/DSZ/1  source-0 channel (`NS_DECLARE_OUT_CHNL(o0)`).
- o0_ack  in  1  source-0 acknowledge.
- o1_*  same as o0_*  source-1 channel.
- i0_src/i0_dst/i0_dat/i0_req  in  ASZ/ASZ/DSZ/1  merged sink channel (`NS_DECLARE_IN_CHNL(i0)`).
- i0_ack  out  1  sink acknowledge.
- o_ck_dat  out  DSZ  last accepted i0_dat.
- o_err  out  1  sticky sink error.
- o_rcv_0, o_rcv_1  out  16  accepted-message counts per source; saturate at 0xFFFF.
- o_done  out  1  high when NUM_MSG≠0 and both counts equal NUM_MSG.
- fst_err_src  out  ASZ  src field of the first erroneous message.
- fst_err_inp  out  DSZ  data of the first erroneous message.
- fst_err_dat  out  DSZ  data expected at the first error.

## Operation
- Channel protocol is a four-phase handshake: req↑, ack↑, req↓, ack↓. Fields are stable while req is high.
- Each source has a 2-state FSM:
  - IDLE, req=0: if ack=0 and the source is not exhausted, load dat={0, cnt[3:0]}, drive req=1, go to REQ.
  - REQ: if ack=1, drive req=0, increment cnt (mod 16) and the sent count, go to IDLE.
- A source is exhausted when NUM_MSG≠0 and its sent count equals NUM_MSG.
- Sink accept condition: i0_req=1 and i0_ack=0. On accept:
  - register i0_dat into o_ck_dat;
  - raise i0_ack;
  - apply the checks below.
- Sink release: when i0_req=0 and i0_ack=1, drop i0_ack.
- Checks on accept (any failing check sets o_err):
  - i0_dst ≠ DST_ADDR;
  - i0_src is neither SRC0_ADDR nor SRC1_ADDR;
  - i0_dat > 15;
  - sequence: if source s already has a baseline, i0_dat[3:0] must equal (last_s+1) mod 16. 15→0 is legal. The first message from s only sets the baseline.
- On accept with a known source, increment o_rcv_s, saturating.
- Sequence expectation on error: last_s is always updated to the received value, so one corrupt word yields one error, not a cascade.

## Timing
- Every output is registered.
- Reset values:
  - all req/ack = 0;
  - cnt = 0;
  - o_ck_dat = 0, o_err = 0;
  - counts = 0, o_done = 0;
  - fst_err_* = 0;
  - baselines cleared.
- Source req rises 1 cycle after it sees ack=0 in IDLE, and falls 1 cycle after it sees ack=1.
- Sink ack rises 1 cycle after req is seen high, and falls 1 cycle after req is seen low.
- o_err, counters and first-error registers update on the same edge that raises i0_ack.
- Reset overrides everything, including mid-handshake: the next edge forces all registers to reset values. The bench must also return its channels idle.
- Both sources may hold req simultaneously. Arbitration is external, and each source is fully independent.

## Configuration
- NS_IO_2TO1_FST_ERR_EN defined: fst_err_src/inp/dat capture the first failing message (fst_err_dat = expected value, or 0 if the failing check is not a sequence check). The registers then freeze until reset.
- Macro undefined: capture logic is omitted, and the three fst_err_* outputs are tied to 0. o_err is unaffected.

## Structure
- Shared package/header (hglobal.v): channel declare/assign macros, `NS_ON/`NS_OFF, address/data size defaults, and the FSM state constants IDLE/REQ.
- One sub-module, io_2to1_src. It is instantiated twice and holds the source FSM, the counter and exhaustion logic. The sink and checker stay in the top.

## Test plan
1. o0 looped directly to i0, o1_ack tied 0, NUM_MSG=0, 40 messages → dat 0..15,0..15,0..7; o_rcv_0=40; o_err=0; o1_req stuck 1.
2. Round-robin bench arbiter merging o0/o1, NUM_MSG=20 → o_rcv_0=o_rcv_1=20; o_done=1; both wrap 15→0; o_err=0; both req stay 0 afterward.
3. Loopback with message dat=5 replaced by 7 → o_err=1 on the ack edge; fst_err_inp=7, fst_err_dat=5, fst_err_src=SRC0_ADDR. A later forced error leaves the captures unchanged. Next message 8 passes.
4. Bench rewrites i0_dst=0 on one message → o_err=1, fst_err_dat=0; the count still increments.
5. Bench rewrites i0_src=9 → o_err=1; neither o_rcv changes.
6. i_rst pulsed 1 cycle while o0_req=1 and i0_ack=1 → next cycle all req/ack=0, counts=0, o_err=0. After release, the first message has dat=0 and no error.
